// File: rtl/sipo_receiver.sv
// MSB-first serial-in/parallel-out receiver with START framing and BIT_EN sampling.
// Ports: clk, rst, SI, START, BIT_EN -> PDATA, DATA_VALID, BUSY, PERR; opt. SIPO_PARITY_CHECK_EN.
module sipo_receiver #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SI,
  input  logic             START,
  input  logic             BIT_EN,
  output logic [WIDTH-1:0] PDATA,
  output logic             DATA_VALID,
  output logic             BUSY,
  output logic             PERR
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAR   = 2'd2;

  logic [1:0]       state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] nxt;
  logic             last;

  assign nxt  = {shreg[WIDTH-2:0], SI};
  assign last = BIT_EN && (cnt == 5'(WIDTH-1));
  assign BUSY = (state != S_IDLE);

`ifdef SIPO_PARITY_CHECK_EN
  logic perr_q;
  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      PDATA      <= INIT;
      DATA_VALID <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      DATA_VALID <= 1'b0;
      unique case (1'b1)
        state == S_IDLE: begin
          if (START) begin
            state <= S_SHIFT;
            cnt   <= '0;
          end
        end
        state == S_SHIFT: begin
          if (BIT_EN) begin
            shreg <= nxt;
            cnt   <= cnt + 5'd1;
            if (last) begin
              PDATA      <= nxt;
              DATA_VALID <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
              state      <= S_PAR;
`else
              state      <= S_IDLE;
`endif
            end
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        state == S_PAR: begin
          // Even parity over the word just completed plus the parity bit.
          if (BIT_EN) begin
            perr_q <= (^PDATA) ^ SI;
            state  <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_receiver.sv
// Scoreboard bench for sipo_receiver: words queued at START, checked on DATA_VALID.
// Covers latency, gapped BIT_EN, reset mid-frame, ignored START, loopback, parity.
module tb_sipo_receiver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         si;
  logic         start;
  logic         bit_en;
  logic [W-1:0] pdata;
  logic         data_valid;
  logic         busy;
  logic         perr;

  sipo_receiver #(.WIDTH(W), .INIT('0)) dut (
    .clk        (clk),
    .rst        (rst),
    .SI         (si),
    .START      (start),
    .BIT_EN     (bit_en),
    .PDATA      (pdata),
    .DATA_VALID (data_valid),
    .BUSY       (busy),
    .PERR       (perr)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_dv  = 0;
  int           cyc   = 0;
  int           start_cyc = 0;
  bit           chk_lat = 1'b0;
  logic         prev_dv = 1'b0;
  logic [W-1:0] held;
  logic [W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      n_dv++;
      check("dv_width", {31'd0, prev_dv}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_dv", 32'd1, 32'd0);
      end else begin
        check("pdata", {24'd0, pdata}, {24'd0, sb_q.pop_front()});
      end
      if (chk_lat) begin
        check("latency", cyc - start_cyc, W);
        chk_lat = 1'b0;
      end
    end
    prev_dv = data_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start  = 1'b0;
    bit_en = 1'b0;
    si     = 1'b0;
  endtask

  // gap: BIT_EN period in cycles; smask[k]: also pulse START on bit k
  task automatic send_frame(input logic [W-1:0] word, input int gap,
                            input logic [W-1:0] smask, input logic par);
    sb_q.push_back(word);
    start = 1'b1;
    step();
    start_cyc = cyc;
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      for (int g = 1; g < gap; g++) step();
      if (k == W - 1) check("pdata_hold", {24'd0, pdata}, {24'd0, held});
      si     = word[W-1-k];
      bit_en = 1'b1;
      start  = smask[k];
      step();
      idle_in();
    end
    held = word;
`ifdef SIPO_PARITY_CHECK_EN
    check("busy_parity", {31'd0, busy}, 32'd1);
    for (int g = 1; g < gap; g++) step();
    si     = par;
    bit_en = 1'b1;
    step();
    idle_in();
`else
    if (par) si = 1'b0;
`endif
  endtask

  initial begin
    int dv0;
    logic [W-1:0] tx;
    idle_in();
    rst  = 1'b1;
    held = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_pdata", {24'd0, pdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dv", {31'd0, data_valid}, 32'd0);
    check("rst_perr", {31'd0, perr}, 32'd0);

    // gapped ticks first, so the pre-completion hold check sees INIT
    send_frame(8'h3C, 4, 8'h00, 1'b0);
    step();
    check("busy_after_3c", {31'd0, busy}, 32'd0);

    chk_lat = 1'b1;
    send_frame(8'hA5, 1, 8'h00, 1'b0);
    step();
    check("busy_after_a5", {31'd0, busy}, 32'd0);
    check("lat_seen", {31'd0, chk_lat}, 32'd0);

    // reset after 4 bits of 0xFF
    dv0 = n_dv;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      si = 1'b1; bit_en = 1'b1; step(); idle_in();
    end
    check("busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    held = '0;
    step();
    check("rst_mid_pdata", {24'd0, pdata}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_nodv", n_dv - dv0, 0);
    send_frame(8'h81, 1, 8'h00, 1'b0);
    step();

    // START pulses on bits 2 and 5 must not restart the frame
    dv0 = n_dv;
    send_frame(8'h5A, 2, 8'b0010_0100, 1'b0);
    step(); step(); step();
    check("one_dv_5a", n_dv - dv0, 1);
    check("pdata_5a", {24'd0, pdata}, 32'h5A);

    // loopback from a shift-left transmitter model
    sb_q.push_back(8'hC3);
    tx = 8'hC3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      si = tx[W-1]; bit_en = 1'b1; step(); idle_in();
      tx = {tx[W-2:0], 1'b0};
    end
    held = 8'hC3;
`ifdef SIPO_PARITY_CHECK_EN
    si = 1'b0; bit_en = 1'b1; step(); idle_in();
`endif
    step();
    check("pdata_c3", {24'd0, pdata}, 32'hC3);

    // back-to-back frames
    dv0 = n_dv;
    send_frame(8'h01, 1, 8'h00, 1'b0);
    send_frame(8'h80, 1, 8'h00, 1'b0);
    step(); step();
    check("b2b_dv", n_dv - dv0, 2);

    // parity
    send_frame(8'hA5, 1, 8'h00, 1'b0);
    step();
    check("perr_p0", {31'd0, perr}, 32'd0);
    send_frame(8'hA5, 1, 8'h00, 1'b1);
    step();
`ifdef SIPO_PARITY_CHECK_EN
    check("perr_p1", {31'd0, perr}, 32'd1);
`else
    check("perr_off", {31'd0, perr}, 32'd0);
`endif
    step(); step();
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
